laser_beacon_sequencer: RTL and testbench
=========================================

// Module: laser_beacon_sequencer
// PURPOSE
//  Clock-domain front end and per-revolution sequencer for the laser beacon tower. Synchronises the raw
//  tower signals (encoder A/B, index sync, beacon), keeps the angular position count, and records
//  beacon rise/fall positions per revolution into a slot table. At each index pulse the table is
//  committed to a double-buffered snapshot, which the host reads by address and releases with an ack.
// PARAMETERS
//  POS_W        16  width of position count and stored edge positions
//  MAX_BEACONS   4  slots per revolution (>=1)
//  MIN_WIDTH     2  minimum |fall-rise| in encoder ticks for a beacon to be stored
//  PERIOD_W     24  width of revolution period counter (clk cycles, saturating)
// PORTS
//  clk                 in   1                     system clock
//  rst_n               in   1                     asynchronous active-low reset
//  laser_signal        in   1                     async; beacon present when low
//  laser_sync          in   1                     async; index pulse, rising edge = new revolution
//  laser_cod_a         in   1                     async encoder A (direction)
//  laser_cod_b         in   1                     async encoder B (tick on rising edge)
//  position            out  POS_W                 live position count
//  position_direction  out  1                     1 = counting up (A high at last B rise)
//  beacon_active       out  1                     synchronised ~laser_signal
//  snap_valid          out  1                     snapshot available
//  snap_ack            in   1                     1-cycle pulse; releases snapshot
//  snap_count          out  $clog2(MAX_BEACONS+1) beacons in snapshot
//  snap_overflow       out  1                     beacons dropped (table full) in snapshot revolution
//  snap_missed         out  1                     sticky: a snapshot was overwritten unacked
//  snap_period         out  PERIOD_W              clk cycles of snapshot revolution
//  rd_addr             in   $clog2(MAX_BEACONS)   slot select
//  rd_rise, rd_fall    out  POS_W                 registered slot data, 1-cycle latency
// BEHAVIOUR
//  Reset: every output and all internal state 0; FSM in WAIT_SYNC. Reset mid-operation discards all.
//  Inputs: 2-FF synchroniser + edge detect each; edge pulse valid 2 clk after pin change.
//  Counter: on synced B rise: direction<=A; position +1 if A else -1, mod 2^POS_W (0 -1 -> all ones).
//   Sync rise same cycle as B rise: position<=0, tick lost. Direction still updated.
//  FSM: WAIT_SYNC -> (sync rise) SCAN; no snapshot at first sync, beacons ignored before it.
//   SCAN -> (laser_signal fall) IN_BEACON, rise_pos<=position.
//   IN_BEACON -> (laser_signal rise) SCAN; store {rise_pos,position} if |position-rise_pos| (POS_W
//   two's-complement difference, magnitude) >= MIN_WIDTH and slot free; if table full set ovf.
//  Sync rise in SCAN/IN_BEACON (commit): snap bank <= slot table, count, ovf, period; snap_valid<=1;
//   table, count, ovf, period counter cleared. If snap_valid already 1 and no ack this cycle:
//   overwrite, snap_missed<=1.
//  Simultaneous with commit: beacon end -> included in committed snapshot; beacon start -> belongs
//   to new revolution with rise_pos=0; in IN_BEACON at commit -> beacon closed with fall=pre-reset
//   position (width rule applied), then reopened with rise_pos=0 (straddling beacon split).
//  snap_ack: clears snap_valid and snap_missed next cycle; commit same cycle wins (valid stays 1,
//   missed stays 0). Ack with snap_valid=0 ignored.
//  Period: +1 per clk, saturates at all ones.
//  Read: rd_rise/rd_fall <= bank[rd_addr] if rd_addr<snap_count else 0; bank stable until commit.
// STRUCTURE
//  laser_pkg: beacon_t {rise,fall}, state enum {WAIT_SYNC,SCAN,IN_BEACON}, default widths.
//  Sub-module laser_input_sync: 2-FF synchroniser + rise/fall pulse, instantiated x4.
// TESTING
//  1 Reset: rst_n low mid-scan -> all outputs 0, WAIT_SYNC; beacons before first sync not stored.
//  2 Sync, 10 B ticks A=1, beacon low ticks 3..7, sync -> snap_valid, count 1, rd_addr 0 -> 3/7.
//  3 A=0, 5 ticks from 0 -> position 0xFFFB, position_direction 0; sync+B same cycle -> position 0.
//  4 6 beacons in one rev (MAX=4) -> snap_count 4, snap_overflow 1, slots hold first four.
//  5 2 syncs no ack -> snap_missed 1, second rev data; snap_ack -> valid 0, missed 0.
//  6 1-tick beacon dropped; beacon over sync -> fall=pre-reset pos in old rev, rise=0 in new.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and default widths for the laser beacon tower front end.
package laser_pkg;

  localparam int unsigned LB_POS_W       = 16;
  localparam int unsigned LB_MAX_BEACONS = 4;
  localparam int unsigned LB_MIN_WIDTH   = 2;
  localparam int unsigned LB_PERIOD_W    = 24;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SCAN      = 2'd1,
    IN_BEACON = 2'd2
  } lb_state_e;

  typedef struct packed {
    logic [LB_POS_W-1:0] rise;
    logic [LB_POS_W-1:0] fall;
  } beacon_t;

endpackage

// File: rtl/laser_input_sync.sv
// Two-flop synchroniser for one asynchronous tower pin, with rise/fall pulses
// derived from the synchronised level.
module laser_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/laser_beacon_sequencer.sv
// Laser beacon tower sequencer: encoder position count, per-revolution beacon
// slot table, and a double-buffered snapshot committed at each index pulse.
module laser_beacon_sequencer
  import laser_pkg::*;
#(
  parameter int unsigned POS_W       = LB_POS_W,
  parameter int unsigned MAX_BEACONS = LB_MAX_BEACONS,
  parameter int unsigned MIN_WIDTH   = LB_MIN_WIDTH,
  parameter int unsigned PERIOD_W    = LB_PERIOD_W,
  localparam int unsigned CNT_W      = $clog2(MAX_BEACONS + 1),
  localparam int unsigned ADDR_W     = (MAX_BEACONS > 1) ? $clog2(MAX_BEACONS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                laser_signal,
  input  logic                laser_sync,
  input  logic                laser_cod_a,
  input  logic                laser_cod_b,
  output logic [POS_W-1:0]    position,
  output logic                position_direction,
  output logic                beacon_active,
  output logic                snap_valid,
  input  logic                snap_ack,
  output logic [CNT_W-1:0]    snap_count,
  output logic                snap_overflow,
  output logic                snap_missed,
  output logic [PERIOD_W-1:0] snap_period,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [POS_W-1:0]    rd_rise,
  output logic [POS_W-1:0]    rd_fall
);

  logic a_lvl, a_rise, a_fall;
  logic b_lvl, b_rise, b_fall;
  logic sync_lvl, sync_rise, sync_fall;
  logic sig_lvl, sig_rise, sig_fall;
  logic unused_edges;

  laser_input_sync u_sync_a   (.clk(clk), .rst_n(rst_n), .async_i(laser_cod_a),
                               .level_o(a_lvl), .rise_o(a_rise), .fall_o(a_fall));
  laser_input_sync u_sync_b   (.clk(clk), .rst_n(rst_n), .async_i(laser_cod_b),
                               .level_o(b_lvl), .rise_o(b_rise), .fall_o(b_fall));
  laser_input_sync u_sync_idx (.clk(clk), .rst_n(rst_n), .async_i(laser_sync),
                               .level_o(sync_lvl), .rise_o(sync_rise), .fall_o(sync_fall));
  laser_input_sync u_sync_sig (.clk(clk), .rst_n(rst_n), .async_i(laser_signal),
                               .level_o(sig_lvl), .rise_o(sig_rise), .fall_o(sig_fall));

  assign unused_edges = ^{a_rise, a_fall, b_lvl, b_fall, sync_lvl, sync_fall};

  lb_state_e            state_q;
  logic [POS_W-1:0]     position_q, rise_pos_q, rd_rise_q, rd_fall_q;
  logic                 dir_q, bact_q, ovf_q;
  logic                 snap_valid_q, snap_ovf_q, snap_missed_q;
  logic [CNT_W-1:0]     count_q, count_d, snap_count_q;
  logic [PERIOD_W-1:0]  period_q, period_inc, snap_period_q;
  logic [POS_W-1:0]     tbl_rise_q [MAX_BEACONS];
  logic [POS_W-1:0]     tbl_fall_q [MAX_BEACONS];
  logic [POS_W-1:0]     tbl_rise_d [MAX_BEACONS];
  logic [POS_W-1:0]     tbl_fall_d [MAX_BEACONS];
  logic [POS_W-1:0]     bank_rise_q [MAX_BEACONS];
  logic [POS_W-1:0]     bank_fall_q [MAX_BEACONS];
  logic [POS_W-1:0]     width_diff, width_mag;
  logic                 commit, close, wide, full, store, ovf_set;

  // A sync inside IN_BEACON closes the beacon at the pre-reset position, so
  // the closing slot write is folded into the same-cycle snapshot copy.
  always_comb begin
    commit     = sync_rise && (state_q != WAIT_SYNC);
    width_diff = position_q - rise_pos_q;
    width_mag  = width_diff[POS_W-1] ? -width_diff : width_diff;
    close      = (state_q == IN_BEACON) && (sig_rise || sync_rise);
    wide       = width_mag >= POS_W'(MIN_WIDTH);
    full       = count_q == CNT_W'(MAX_BEACONS);
    store      = close && wide && !full;
    ovf_set    = close && wide && full;
    count_d    = count_q + CNT_W'(store);
    period_inc = (&period_q) ? period_q : period_q + PERIOD_W'(1);
    tbl_rise_d = tbl_rise_q;
    tbl_fall_d = tbl_fall_q;
    if (store) begin
      tbl_rise_d[ADDR_W'(count_q)] = rise_pos_q;
      tbl_fall_d[ADDR_W'(count_q)] = position_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SYNC;
      position_q    <= '0;
      rise_pos_q    <= '0;
      dir_q         <= 1'b0;
      bact_q        <= 1'b0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      period_q      <= '0;
      snap_valid_q  <= 1'b0;
      snap_count_q  <= '0;
      snap_ovf_q    <= 1'b0;
      snap_missed_q <= 1'b0;
      snap_period_q <= '0;
      rd_rise_q     <= '0;
      rd_fall_q     <= '0;
      for (int unsigned i = 0; i < MAX_BEACONS; i++) begin
        tbl_rise_q[i]  <= '0;
        tbl_fall_q[i]  <= '0;
        bank_rise_q[i] <= '0;
        bank_fall_q[i] <= '0;
      end
    end else begin
      bact_q <= ~sig_lvl;
      if (b_rise) dir_q <= a_lvl;
      if (sync_rise)   position_q <= '0;
      else if (b_rise) position_q <= a_lvl ? position_q + POS_W'(1) : position_q - POS_W'(1);

      case (state_q)
        WAIT_SYNC: if (sync_rise) state_q <= SCAN;
        SCAN: if (sig_fall) begin
          state_q    <= IN_BEACON;
          rise_pos_q <= sync_rise ? '0 : position_q;
        end
        IN_BEACON: begin
          if (sig_rise)       state_q    <= SCAN;
          else if (sync_rise) rise_pos_q <= '0;
        end
        default: state_q <= WAIT_SYNC;
      endcase

      tbl_rise_q <= tbl_rise_d;
      tbl_fall_q <= tbl_fall_d;
      period_q   <= sync_rise ? '0 : period_inc;

      if (commit) begin
        bank_rise_q   <= tbl_rise_d;
        bank_fall_q   <= tbl_fall_d;
        snap_count_q  <= count_d;
        snap_ovf_q    <= ovf_q | ovf_set;
        snap_period_q <= period_inc;
        snap_valid_q  <= 1'b1;
        snap_missed_q <= snap_valid_q && !snap_ack;
        count_q       <= '0;
        ovf_q         <= 1'b0;
      end else begin
        count_q <= count_d;
        ovf_q   <= ovf_q | ovf_set;
        if (snap_ack && snap_valid_q) begin
          snap_valid_q  <= 1'b0;
          snap_missed_q <= 1'b0;
        end
      end

      if (CNT_W'(rd_addr) < snap_count_q) begin
        rd_rise_q <= bank_rise_q[rd_addr];
        rd_fall_q <= bank_fall_q[rd_addr];
      end else begin
        rd_rise_q <= '0;
        rd_fall_q <= '0;
      end
    end
  end

  assign position           = position_q;
  assign position_direction = dir_q;
  assign beacon_active      = bact_q;
  assign snap_valid         = snap_valid_q;
  assign snap_count         = snap_count_q;
  assign snap_overflow      = snap_ovf_q;
  assign snap_missed        = snap_missed_q;
  assign snap_period        = snap_period_q;
  assign rd_rise            = rd_rise_q;
  assign rd_fall            = rd_fall_q;

endmodule

// File: tb/tb_laser_beacon_sequencer.sv
// Directed bench for laser_beacon_sequencer: position counting, beacon capture,
// snapshot commit/ack/overwrite, straddling beacons and mid-operation reset.
module tb_laser_beacon_sequencer;

  logic        clk;
  logic        rst_n;
  logic        laser_signal, laser_sync, laser_cod_a, laser_cod_b;
  logic [15:0] position;
  logic        position_direction, beacon_active;
  logic        snap_valid, snap_ack, snap_overflow, snap_missed;
  logic [2:0]  snap_count;
  logic [23:0] snap_period;
  logic [1:0]  rd_addr;
  logic [15:0] rd_rise, rd_fall;

  int n_vec = 0;
  int n_bad = 0;

  laser_beacon_sequencer #(
    .POS_W(16), .MAX_BEACONS(4), .MIN_WIDTH(2), .PERIOD_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .laser_signal(laser_signal), .laser_sync(laser_sync),
    .laser_cod_a(laser_cod_a), .laser_cod_b(laser_cod_b),
    .position(position), .position_direction(position_direction),
    .beacon_active(beacon_active), .snap_valid(snap_valid), .snap_ack(snap_ack),
    .snap_count(snap_count), .snap_overflow(snap_overflow), .snap_missed(snap_missed),
    .snap_period(snap_period), .rd_addr(rd_addr), .rd_rise(rd_rise), .rd_fall(rd_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v);
    laser_cod_a = v;
    repeat (3) tick();
  endtask

  task automatic pulse_b();
    laser_cod_b = 1'b1;
    repeat (3) tick();
    laser_cod_b = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_sig(input logic v);
    laser_signal = v;
    repeat (3) tick();
  endtask

  task automatic sync_pulse();
    laser_sync = 1'b1;
    repeat (3) tick();
    laser_sync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ack_pulse();
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [15:0] er, input logic [15:0] ef);
    rd_addr = a;
    repeat (2) tick();
    chk("rd_rise", rd_rise, er);
    chk("rd_fall", rd_fall, ef);
  endtask

  initial begin
    rst_n = 1'b0; laser_signal = 1'b1; laser_sync = 1'b0;
    laser_cod_a = 1'b0; laser_cod_b = 1'b0; snap_ack = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_pos", position, 0);
    chk("rst_valid", snap_valid, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_bact", beacon_active, 0);

    // Count down from 0 before any sync
    set_a(1'b0);
    repeat (5) pulse_b();
    chk("down_pos", position, 16'hFFFB);
    chk("down_dir", position_direction, 0);
    set_sig(1'b0);
    chk("bact_on", beacon_active, 1);
    pulse_b();
    set_sig(1'b1);
    chk("bact_off", beacon_active, 0);

    // First sync: no snapshot; single beacon 3..7
    sync_pulse();
    chk("sync_pos0", position, 0);
    chk("first_sync_nosnap", snap_valid, 0);
    set_a(1'b1);
    for (int i = 1; i <= 10; i++) begin
      pulse_b();
      if (i == 3) set_sig(1'b0);
      if (i == 7) set_sig(1'b1);
    end
    chk("up_pos", position, 10);
    chk("up_dir", position_direction, 1);
    sync_pulse();
    chk("t2_valid", snap_valid, 1);
    chk("t2_count", snap_count, 1);
    chk("t2_ovf", snap_overflow, 0);
    chk("t2_missed", snap_missed, 0);
    rd_chk(2'd0, 16'd3, 16'd7);
    rd_chk(2'd1, 16'd0, 16'd0);
    ack_pulse();
    chk("t2_ack_valid", snap_valid, 0);

    // Six beacons, table holds four
    for (int k = 0; k < 6; k++) begin
      set_sig(1'b0);
      repeat (2) pulse_b();
      set_sig(1'b1);
      pulse_b();
    end
    sync_pulse();
    chk("t4_count", snap_count, 4);
    chk("t4_ovf", snap_overflow, 1);
    for (int k = 0; k < 4; k++) rd_chk(2'(k), 16'(3 * k), 16'(3 * k + 2));

    // Overwrite without ack
    set_sig(1'b0);
    repeat (4) pulse_b();
    set_sig(1'b1);
    sync_pulse();
    chk("t5_missed", snap_missed, 1);
    chk("t5_valid", snap_valid, 1);
    chk("t5_count", snap_count, 1);
    chk("t5_ovf", snap_overflow, 0);
    rd_chk(2'd0, 16'd0, 16'd4);
    ack_pulse();
    chk("t5_ack_valid", snap_valid, 0);
    chk("t5_ack_missed", snap_missed, 0);

    // Revolution of exactly 20 clocks
    sync_pulse();
    repeat (14) tick();
    sync_pulse();
    chk("period20", snap_period, 20);
    chk("period_count", snap_count, 0);
    chk("period_missed", snap_missed, 1);
    ack_pulse();

    // Narrow beacon dropped, then a beacon straddling the sync
    set_sig(1'b0);
    pulse_b();
    set_sig(1'b1);
    pulse_b();
    set_sig(1'b0);
    repeat (3) pulse_b();
    sync_pulse();
    chk("t6_count_old", snap_count, 1);
    chk("t6_missed", snap_missed, 0);
    rd_chk(2'd0, 16'd2, 16'd5);
    ack_pulse();
    repeat (2) pulse_b();
    set_sig(1'b1);
    sync_pulse();
    chk("t6_count_new", snap_count, 1);
    rd_chk(2'd0, 16'd0, 16'd2);

    // Sync coincident with B rise: tick lost, direction still taken
    repeat (3) pulse_b();
    chk("pre_coinc_pos", position, 3);
    set_a(1'b0);
    laser_sync = 1'b1; laser_cod_b = 1'b1;
    repeat (3) tick();
    laser_sync = 1'b0; laser_cod_b = 1'b0;
    repeat (3) tick();
    chk("coinc_pos", position, 0);
    chk("coinc_dir", position_direction, 0);
    chk("coinc_missed", snap_missed, 1);

    // Ack landing on the commit cycle
    laser_sync = 1'b1;
    repeat (2) tick();
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    repeat (4) tick();
    laser_sync = 1'b0;
    repeat (3) tick();
    chk("ackcommit_valid", snap_valid, 1);
    chk("ackcommit_missed", snap_missed, 0);
    chk("ackcommit_count", snap_count, 0);

    // Reset in the middle of a beacon
    set_sig(1'b0);
    pulse_b();
    rst_n = 1'b0;
    laser_signal = 1'b1;
    repeat (2) tick();
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_dir", position_direction, 0);
    chk("mid_rst_bact", beacon_active, 0);
    chk("mid_rst_valid", snap_valid, 0);
    chk("mid_rst_count", snap_count, 0);
    chk("mid_rst_ovf", snap_overflow, 0);
    chk("mid_rst_missed", snap_missed, 0);
    chk("mid_rst_period", snap_period, 0);
    chk("mid_rst_rd_rise", rd_rise, 0);
    chk("mid_rst_rd_fall", rd_fall, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    set_sig(1'b0);
    repeat (3) pulse_b();
    set_sig(1'b1);
    sync_pulse();
    chk("post_rst_first_sync", snap_valid, 0);
    sync_pulse();
    chk("post_rst_valid", snap_valid, 1);
    chk("post_rst_count", snap_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
